// File: rtl/icache_arb_pkg.sv
// Shared types and helpers for the instruction-cache refill arbiter.
package icache_arb_pkg;

  localparam int unsigned MaxReqBits            = 32'd64;
  localparam int          DefNumCaches          = 4;
  localparam int          DefCachelineAddrWidth = 31;
  localparam int          DefCachelineIdxBits   = 1;
  localparam int          DefEncInstWidth       = 32;

  function automatic int calc_id_width(input int num);
    if (num > 1) begin
      return $clog2(num);
    end else begin
      return 1;
    end
  endfunction

  localparam int DefIdWidth = calc_id_width(DefNumCaches);

  typedef logic [DefCachelineAddrWidth-1:0]                           cache_addr_t;
  typedef logic [(1 << DefCachelineIdxBits)-1:0][DefEncInstWidth-1:0] cache_data_t;
  typedef logic [DefIdWidth-1:0]                                      cache_id_t;

  // First set bit of req at or above ptr, wrapping modulo num (ptr < num <= MaxReqBits).
  function automatic int unsigned rr_first(input logic [MaxReqBits-1:0] req,
                                           input int unsigned ptr,
                                           input int unsigned num);
    int unsigned idx;
    logic        found;
    int unsigned result;
    found  = 1'b0;
    result = 32'd0;
    for (int unsigned k = 32'd0; k < MaxReqBits; k++) begin
      idx = ptr + k;
      if (idx >= num) begin
        idx = idx - num;
      end else begin
        idx = idx;
      end
      if ((k < num) && !found && req[idx[5:0]]) begin
        found  = 1'b1;
        result = idx;
      end else begin
        found = found;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/icache_arb_checker.sv
// Protocol checks for the refill arbiter; no synthesizable logic.
module icache_arb_checker #(
  parameter int NumCaches = 4
) (
  input logic                 clk_i,
  input logic                 rst_i,
  input logic                 mem_valid_i,
  input logic                 fifo_empty_i,
  input logic [NumCaches-1:0] ic_valid_i
);

  spurious_rsp_a: assert property (@(posedge clk_i) disable iff (rst_i)
                                   !(mem_valid_i && fifo_empty_i))
    else $warning("icache_mem_arbiter: memory response with no request outstanding");

  onehot_valid_a: assert property (@(posedge clk_i) disable iff (rst_i)
                                   $onehot0(ic_valid_i))
    else $error("icache_mem_arbiter: more than one response valid");

endmodule

// File: rtl/icache_arb_owner_fifo.sv
// In-order owner FIFO with synchronous active-high reset; any depth >= 1.
module icache_arb_owner_fifo
  import icache_arb_pkg::*;
#(
  parameter int Depth = 4,
  parameter int Width = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [Width-1:0]             data_i,
  input  logic                         pop_i,
  output logic [Width-1:0]             head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   fill_o
);

  localparam int PtrWidth  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int FillWidth = $clog2(Depth + 1);

  logic [Width-1:0]     mem_q [Depth];
  logic [PtrWidth-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [FillWidth-1:0] fill_q, fill_d;
  logic                 push_s, pop_s;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    if (p == PtrWidth'(Depth - 1)) begin
      return '0;
    end else begin
      return p + PtrWidth'(1);
    end
  endfunction

  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_o;
  assign full_o  = (fill_q == FillWidth'(Depth));
  assign empty_o = (fill_q == '0);
  assign head_o  = mem_q[rd_q];
  assign fill_o  = fill_q;

  // Pointer and fill-level next state; push and pop together keep the level.
  always_comb begin
    wr_d = push_s ? ptr_inc(wr_q) : wr_q;
    rd_d = pop_s ? ptr_inc(rd_q) : rd_q;
    case ({push_s, pop_s})
      2'b10:   fill_d = fill_q + FillWidth'(1);
      2'b01:   fill_d = fill_q - FillWidth'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fill_q <= fill_d;
      if (push_s) begin
        mem_q[wr_q] <= data_i;
      end
    end
  end

endmodule

// File: rtl/icache_mem_arbiter.sv
// Round-robin arbiter sharing one instruction-memory refill port between
// several instruction caches, routing in-order responses back to their owner.
module icache_mem_arbiter
  import icache_arb_pkg::*;
#(
  parameter int NumCaches          = 4,
  parameter int CachelineAddrWidth = 31,
  parameter int CachelineIdxBits   = 1,
  parameter int EncInstWidth       = 32,
  parameter int MaxOutstanding     = 4
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_i,
  input  logic [NumCaches-1:0]                                  ic_req_i,
  input  logic [NumCaches-1:0][CachelineAddrWidth-1:0]          ic_addr_i,
  output logic [NumCaches-1:0]                                  ic_ready_o,
  output logic [NumCaches-1:0]                                  ic_valid_o,
  output logic [(1 << CachelineIdxBits)-1:0][EncInstWidth-1:0]  ic_data_o,
  output logic                                                  mem_req_o,
  output logic [CachelineAddrWidth-1:0]                         mem_addr_o,
  input  logic                                                  mem_ready_i,
  input  logic                                                  mem_valid_i,
  input  logic [(1 << CachelineIdxBits)-1:0][EncInstWidth-1:0]  mem_data_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]                   outstanding_o,
  output logic                                                  err_rsp_o
);

  localparam int IdWidth = calc_id_width(NumCaches);

  logic [IdWidth-1:0]    rr_q, rr_d, winner_s, head_s;
  logic [MaxReqBits-1:0] req_ext_s;
  logic                  any_req_s, fifo_full_s, fifo_empty_s, handshake_s, pop_s;

  assign req_ext_s = MaxReqBits'(ic_req_i);
  assign any_req_s = |ic_req_i;
  assign winner_s  = IdWidth'(rr_first(req_ext_s, 32'(rr_q), 32'(NumCaches)));

  // Full blocks issue even when a pop lands in the same cycle, so mem_valid_i
  // never reaches mem_req_o combinationally.
  assign mem_req_o   = ~rst_i & any_req_s & ~fifo_full_s;
  assign handshake_s = mem_req_o & mem_ready_i;
  assign pop_s       = ~rst_i & mem_valid_i & ~fifo_empty_s;
  assign err_rsp_o   = ~rst_i & mem_valid_i & fifo_empty_s;

  always_comb begin
    ic_ready_o = '0;
    if (mem_req_o) begin
      mem_addr_o = ic_addr_i[winner_s];
    end else begin
      mem_addr_o = '0;
    end
    if (handshake_s) begin
      ic_ready_o[winner_s] = 1'b1;
    end else begin
      ic_ready_o = '0;
    end
  end

  always_comb begin
    ic_valid_o = '0;
    if (pop_s) begin
      ic_valid_o[head_s] = 1'b1;
      ic_data_o          = mem_data_i;
    end else begin
      ic_data_o = '0;
    end
  end

  // Pointer only moves on an accepted issue, so a stalled grant stays put.
  always_comb begin
    if (handshake_s) begin
      if (winner_s == IdWidth'(NumCaches - 1)) begin
        rr_d = '0;
      end else begin
        rr_d = winner_s + IdWidth'(1);
      end
    end else begin
      rr_d = rr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  icache_arb_owner_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdWidth)
  ) u_owner_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (handshake_s),
    .data_i  (winner_s),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .fill_o  (outstanding_o)
  );

  icache_arb_checker #(
    .NumCaches (NumCaches)
  ) u_checker (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .mem_valid_i  (mem_valid_i),
    .fifo_empty_i (fifo_empty_s),
    .ic_valid_i   (ic_valid_o)
  );

endmodule

// File: tb/tb_icache_mem_arbiter.sv
// Directed vector table plus randomized run against a queue-based reference model.
module tb_icache_mem_arbiter;
  import icache_arb_pkg::*;

  localparam int NC = 4;
  localparam int AW = 31;
  localparam int IB = 1;
  localparam int EW = 32;
  localparam int MO = 3;
  localparam int OW = $clog2(MO + 1);

  logic                           clk = 1'b0;
  logic                           rst;
  logic [NC-1:0]                  ic_req;
  logic [NC-1:0][AW-1:0]          ic_addr;
  logic [NC-1:0]                  ic_ready, ic_valid;
  logic [(1 << IB)-1:0][EW-1:0]   ic_data, mem_data;
  logic                           mem_req, mem_ready, mem_valid, err_rsp;
  logic [AW-1:0]                  mem_addr;
  logic [OW-1:0]                  outstanding;

  always #5 clk = ~clk;

  icache_mem_arbiter #(
    .NumCaches          (NC),
    .CachelineAddrWidth (AW),
    .CachelineIdxBits   (IB),
    .EncInstWidth       (EW),
    .MaxOutstanding     (MO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .ic_req_i      (ic_req),
    .ic_addr_i     (ic_addr),
    .ic_ready_o    (ic_ready),
    .ic_valid_o    (ic_valid),
    .ic_data_o     (ic_data),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_ready_i   (mem_ready),
    .mem_valid_i   (mem_valid),
    .mem_data_i    (mem_data),
    .outstanding_o (outstanding),
    .err_rsp_o     (err_rsp)
  );

  typedef struct {
    logic          rst;
    logic [NC-1:0] req;
    logic          rdy;
    logic          vld;
    logic          e_req;
    logic [AW-1:0] e_addr;
    logic [NC-1:0] e_rdy;
    logic [NC-1:0] e_vld;
    logic          e_err;
    logic [OW-1:0] e_out;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: round-robin pointer and queue of owners.
  int   rr_m;
  int   own_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic y, input logic v,
                     input logic er, input logic [AW-1:0] ea, input logic [3:0] ey,
                     input logic [3:0] ev, input logic ee, input logic [OW-1:0] eo);
    vec_t t;
    t.rst = r; t.req = q; t.rdy = y; t.vld = v;
    t.e_req = er; t.e_addr = ea; t.e_rdy = ey; t.e_vld = ev; t.e_err = ee; t.e_out = eo;
    tbl.push_back(t);
  endtask

  function automatic int pick(input logic [NC-1:0] r, input int p);
    for (int k = 0; k < NC; k++) begin
      if (((r >> ((p + k) % NC)) & 4'd1) != 4'd0) return (p + k) % NC;
    end
    return -1;
  endfunction

  task automatic check_all(input string tag, input logic e_req, input logic [AW-1:0] e_addr,
                           input logic [NC-1:0] e_rdy, input logic [NC-1:0] e_vld,
                           input logic [63:0] e_data, input logic e_err, input logic [OW-1:0] e_out);
    chk({tag, ".mem_req"},     64'(mem_req),     64'(e_req));
    chk({tag, ".mem_addr"},    64'(mem_addr),    64'(e_addr));
    chk({tag, ".ic_ready"},    64'(ic_ready),    64'(e_rdy));
    chk({tag, ".ic_valid"},    64'(ic_valid),    64'(e_vld));
    chk({tag, ".ic_data"},     64'(ic_data),     e_data);
    chk({tag, ".err_rsp"},     64'(err_rsp),     64'(e_err));
    chk({tag, ".outstanding"}, 64'(outstanding), 64'(e_out));
  endtask

  initial begin
    logic [63:0] fixed_data;
    fixed_data = 64'hDEAD_BEEF_1234_5678;

    //   rst   req     rdy   vld   e_req e_addr  e_rdy   e_vld   e_err e_out
    add(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 31'h00, 4'b0000, 4'b0000, 1'b0, 2'd0); // reset state
    add(1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 31'h40, 4'b0100, 4'b0000, 1'b0, 2'd0); // single requester
    add(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 31'h00, 4'b0000, 4'b0000, 1'b0, 2'd1);
    add(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 31'h00, 4'b0000, 4'b0100, 1'b0, 2'd1);
    add(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 31'h00, 4'b0000, 4'b0000, 1'b0, 2'd0);
    add(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 31'h00, 4'b0000, 4'b0000, 1'b1, 2'd0); // spurious
    add(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 31'h00, 4'b0000, 4'b0000, 1'b0, 2'd0);
    add(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 31'h00, 4'b0000, 4'b0000, 1'b0, 2'd0); // rr back to 0
    add(1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 31'h10, 4'b0001, 4'b0000, 1'b0, 2'd0); // fairness
    add(1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 31'h20, 4'b0010, 4'b0000, 1'b0, 2'd1);
    add(1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 31'h40, 4'b0100, 4'b0000, 1'b0, 2'd2);
    add(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 31'h00, 4'b0000, 4'b0000, 1'b0, 2'd3); // full
    add(1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 31'h00, 4'b0000, 4'b0001, 1'b0, 2'd3); // full + pop
    add(1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 31'h80, 4'b1000, 4'b0000, 1'b0, 2'd2); // resumes
    add(1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 31'h00, 4'b0000, 4'b0010, 1'b0, 2'd3);
    add(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 31'h00, 4'b0000, 4'b0100, 1'b0, 2'd2);
    add(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 31'h00, 4'b0000, 4'b1000, 1'b0, 2'd1);
    add(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 31'h00, 4'b0000, 4'b0000, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) begin                                            // backpressure
      add(1'b0, 4'b1010, 1'b0, 1'b0, 1'b1, 31'h20, 4'b0000, 4'b0000, 1'b0, 2'd0);
    end
    add(1'b0, 4'b1010, 1'b1, 1'b0, 1'b1, 31'h20, 4'b0010, 4'b0000, 1'b0, 2'd0);
    add(1'b0, 4'b1010, 1'b1, 1'b0, 1'b1, 31'h80, 4'b1000, 4'b0000, 1'b0, 2'd1);
    add(1'b0, 4'b0001, 1'b1, 1'b1, 1'b1, 31'h10, 4'b0001, 4'b0010, 1'b0, 2'd2); // push+pop
    add(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 31'h00, 4'b0000, 4'b0000, 1'b0, 2'd2); // mid-op reset
    add(1'b0, 4'b1000, 1'b1, 1'b0, 1'b1, 31'h80, 4'b1000, 4'b0000, 1'b0, 2'd0);
    add(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 31'h00, 4'b0000, 4'b1000, 1'b0, 2'd1);
    add(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 31'h00, 4'b0000, 4'b0000, 1'b0, 2'd0);

    rst = 1'b1; ic_req = '0; mem_ready = 1'b0; mem_valid = 1'b0; mem_data = '0;
    ic_addr[0] = 31'h10; ic_addr[1] = 31'h20; ic_addr[2] = 31'h40; ic_addr[3] = 31'h80;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; ic_req = tbl[i].req; mem_ready = tbl[i].rdy; mem_valid = tbl[i].vld;
      mem_data = fixed_data;
      #4;
      check_all($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_rdy, tbl[i].e_vld,
                (tbl[i].e_vld != 4'b0000) ? fixed_data : 64'd0, tbl[i].e_err, tbl[i].e_out);
      @(posedge clk);
      #1;
    end

    // Randomized phase; first cycle resets so model and DUT start aligned.
    rr_m = 0;
    own_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic          e_req, hs, pop;
      logic [NC-1:0] e_rdy, e_vld;
      logic [AW-1:0] e_addr;
      logic [63:0]   e_data;
      int            w;
      rst       = (cyc == 0) || ($urandom_range(0, 199) == 0);
      ic_req    = NC'($urandom);
      mem_ready = ($urandom_range(0, 3) != 0);
      mem_valid = ($urandom_range(0, 2) == 0);
      for (int c = 0; c < NC; c++) ic_addr[c] = AW'($urandom);
      mem_data  = {$urandom, $urandom};
      #4;
      w      = pick(ic_req, rr_m);
      e_req  = !rst && (w >= 0) && (own_q.size() < MO);
      e_addr = e_req ? ic_addr[w] : '0;
      hs     = e_req && mem_ready;
      e_rdy  = hs ? NC'(1 << w) : '0;
      pop    = !rst && mem_valid && (own_q.size() > 0);
      e_vld  = pop ? NC'(1 << own_q[0]) : '0;
      e_data = pop ? 64'(mem_data) : 64'd0;
      check_all($sformatf("rnd%0d", cyc), e_req, e_addr, e_rdy, e_vld, e_data,
                !rst && mem_valid && (own_q.size() == 0), OW'(own_q.size()));
      @(posedge clk);
      if (rst) begin
        own_q.delete();
        rr_m = 0;
      end else begin
        if (pop) void'(own_q.pop_front());
        if (hs) begin
          own_q.push_back(w);
          rr_m = (w + 1) % NC;
        end
      end
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
